aes_key_schedule_ctrl: RTL

Iterative AES-128 key-expansion controller. It accepts a 128-bit cipher key over a valid/ready handshake and steps the existing combinational round-key generator (GENERATE_KEY) once per cycle over rounds 0..9. All 11 round keys are written into an internal key store. The cipher round core reads round keys by index through a registered read port and waits for keys_valid before using them.

---
 rtl/aes_pkg.sv | 75 +++++++
 rtl/aes_key_schedule_ctrl_generate_key.sv | 31 +++
 rtl/aes_key_schedule_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, key-schedule state encoding and byte-level
// helpers (GF(2^8) arithmetic, S-box, round constant) used by the key schedule.
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_READY  = 2'd2
    } ks_state_t;

    typedef logic [3:0] round_idx_t;

    // Multiply two elements of GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    // Forward AES S-box: field inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Round constant for expansion step 0..9; out-of-range steps give 0.
    function automatic logic [7:0] rcon(input round_idx_t r);
        logic [7:0] c;
        case (r)
            4'd0:    c = 8'h01;
            4'd1:    c = 8'h02;
            4'd2:    c = 8'h04;
            4'd3:    c = 8'h08;
            4'd4:    c = 8'h10;
            4'd5:    c = 8'h20;
            4'd6:    c = 8'h40;
            4'd7:    c = 8'h80;
            4'd8:    c = 8'h1b;
            4'd9:    c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_generate_key.sv
// Combinational AES-128 round-key generator: derives round key r+1 from
// round key r in a single step.
module GENERATE_KEY
    import aes_pkg::*;
(
    input  round_idx_t             round,
    input  logic [AES_KEY_W-1:0]   inp_key,
    output logic [AES_KEY_W-1:0]   out_key
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] rot_s, temp_s;
    logic [31:0] w4_s, w5_s, w6_s, w7_s;

    // Word-wise expansion: RotWord/SubWord/Rcon on the last word, then XOR chain.
    always_comb begin
        w0_s   = inp_key[127:96];
        w1_s   = inp_key[95:64];
        w2_s   = inp_key[63:32];
        w3_s   = inp_key[31:0];
        rot_s  = {w3_s[23:0], w3_s[31:24]};
        temp_s = {sbox(rot_s[31:24]) ^ rcon(round), sbox(rot_s[23:16]),
                  sbox(rot_s[15:8]), sbox(rot_s[7:0])};
        w4_s   = w0_s ^ temp_s;
        w5_s   = w4_s ^ w1_s;
        w6_s   = w5_s ^ w2_s;
        w7_s   = w6_s ^ w3_s;
        out_key = {w4_s, w5_s, w6_s, w7_s};
    end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key-expansion controller: accepts a cipher key, steps the
// round-key generator once per cycle and fills an 11-entry round-key store
// that the cipher core reads through a registered port.
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_W      = AES_KEY_W,
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_in_valid,
    output logic              key_in_ready,
    input  logic              abort,
    output logic              busy,
    output logic              keys_valid,
    output logic [3:0]        round_cnt,
    input  logic [3:0]        rk_rd_idx,
    output logic [KEY_W-1:0]  rk_rd_data
);

    localparam round_idx_t LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam round_idx_t LAST_IDX   = 4'(NUM_ROUNDS);

    ks_state_t         state_r;
    round_idx_t        round_cnt_r;
    logic              busy_r;
    logic              keys_valid_r;
    logic [KEY_W-1:0]  cur_key_r;
    logic [KEY_W-1:0]  rd_data_r;
    logic [KEY_W-1:0]  store_r [0:NUM_ROUNDS];

    logic [KEY_W-1:0]  gen_key_s;
    round_idx_t        wr_idx_s;
    logic              accept_s;
    logic              rd_in_range_s;

    GENERATE_KEY u_generate_key (
        .round   (round_cnt_r),
        .inp_key (cur_key_r),
        .out_key (gen_key_s)
    );

    // Handshake decode, store write index and read-range check.
    always_comb begin
        key_in_ready  = (state_r != KS_EXPAND);
        accept_s      = key_in_valid & key_in_ready;
        wr_idx_s      = round_cnt_r + 4'd1;
        rd_in_range_s = (rk_rd_idx <= LAST_IDX);
    end

    // Controller FSM, key store updates and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= KS_IDLE;
            round_cnt_r  <= 4'd0;
            busy_r       <= 1'b0;
            keys_valid_r <= 1'b0;
            cur_key_r    <= '0;
            rd_data_r    <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                store_r[i] <= '0;
            end
        end else begin
            // Non-blocking read: a same-cycle write is seen on the next read.
            if (rd_in_range_s) begin
                rd_data_r <= store_r[rk_rd_idx];
            end else begin
                rd_data_r <= '0;
            end

            case (state_r)
                KS_IDLE, KS_READY: begin
                    // Abort is meaningless outside EXPAND and is dropped here.
                    if (accept_s) begin
                        store_r[0]   <= key_in;
                        cur_key_r    <= key_in;
                        round_cnt_r  <= 4'd0;
                        keys_valid_r <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= KS_EXPAND;
                    end
                end
                KS_EXPAND: begin
                    if (abort) begin
                        // Entries already written stay but are not flagged valid.
                        state_r      <= KS_IDLE;
                        busy_r       <= 1'b0;
                        keys_valid_r <= 1'b0;
                        round_cnt_r  <= 4'd0;
                    end else begin
                        store_r[wr_idx_s] <= gen_key_s;
                        cur_key_r         <= gen_key_s;
                        if (round_cnt_r == LAST_ROUND) begin
                            state_r      <= KS_READY;
                            busy_r       <= 1'b0;
                            keys_valid_r <= 1'b1;
                            round_cnt_r  <= 4'd0;
                        end else begin
                            round_cnt_r <= round_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r      <= KS_IDLE;
                    busy_r       <= 1'b0;
                    keys_valid_r <= 1'b0;
                    round_cnt_r  <= 4'd0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign keys_valid = keys_valid_r;
    assign round_cnt  = round_cnt_r;
    assign rk_rd_data = rd_data_r;

endmodule
